multicycle_control_unit: RTL and testbench

// FSM that sequences a multicycle MIPS datapath. The datapath has shared PC, IR, A, B and ALUOut registers, one unified

---
 rtl/multicycle_control_unit_if.sv | 44 ++++
 rtl/multicycle_control_unit.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// ============================================================================
// Module  : multicycle_control_unit_if
// Purpose : Control strobes and memory handshake between the multicycle
//           control unit and its datapath.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface multicycle_control_unit_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;
  logic       bus_error;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_req, mem_we, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, bus_error, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_req, mem_we, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, bus_error, state
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module  : multicycle_control_unit
// Purpose : Sequencing FSM for a multicycle MIPS datapath with a memory
//           watchdog.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_error_q, bus_error_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = '0;
    bus_error_d       = bus_error_q | (state_q == S_FAULT);
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_src        = 2'b00;
    bus.illegal_op    = 1'b0;

    // Memory states share one stall policy: ready wins, else count or fault.
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) &&
        !bus.mem_ready) begin
      if (wait_cnt_q == LAST_WAIT) state_d = S_FAULT;
      else                         wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.iord    = 1'b1;
        bus.mem_req = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.iord    = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_src        = 2'b01;
        bus.pc_write_cond = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.bus_error = bus_error_q;
  assign bus.state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module  : tb_multicycle_control_unit
// Purpose : Scoreboard bench for the multicycle control unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  // {state, pcw, pcwc, iord, req, we, irw, rdst, m2r, rw, asa, alu_src_b, alu_op, pc_src, ill}
  localparam logic [20:0] V_IDLE   = {4'd0,  10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_FETCH  = {4'd1,  10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_DECODE = {4'd2,  10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_DECILL = {4'd2,  10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [20:0] V_MEMADR = {4'd3,  10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMRD  = {4'd4,  10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMWB  = {4'd5,  10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_MEMWR  = {4'd6,  10'b0011100000, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_EXEC   = {4'd7,  10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
  localparam logic [20:0] V_ALUWB  = {4'd8,  10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_BRANCH = {4'd9,  10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
  localparam logic [20:0] V_JUMP   = {4'd10, 10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
  localparam logic [20:0] V_ADDIEX = {4'd11, 10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_ADDIWB = {4'd12, 10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [20:0] V_FAULT  = {4'd15, 10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b0};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    logic        rdy;
    logic [5:0]  opc;
    logic [20:0] vec;
  } sb_t;

  logic  clk = 1'b0;
  logic  rst;
  sb_t   sb[$];
  sb_t   e;
  int    n_cmp = 0;
  int    n_err = 0;
  logic [20:0] w_obs;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign w_obs = {bus.state, bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_req,
                  bus.mem_we, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};

  task automatic push(input logic r, input logic [5:0] o, input logic [20:0] v);
    sb_t t;
    t.rdy = r; t.opc = o; t.vec = v;
    sb.push_back(t);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.mem_ready = 1'b1; bus.opcode = RT;
    #1;
    n_cmp++;
    if (w_obs !== 21'd0 || bus.bus_error !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got %h/%b need 000000/0", w_obs, bus.bus_error);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(1'b1, RT, V_IDLE);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL reset_release: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    push(1, LW, V_FETCH); push(1, LW, V_DECODE); push(1, LW, V_MEMADR);
    push(1, LW, V_MEMRD); push(1, LW, V_MEMWB);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL lw_seq: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    push(1, RT, V_FETCH); push(1, RT, V_DECODE); push(1, RT, V_EXEC); push(1, RT, V_ALUWB);
    push(1, BEQ, V_FETCH); push(1, BEQ, V_DECODE); push(1, BEQ, V_BRANCH);
    push(1, J, V_FETCH); push(1, J, V_DECODE); push(1, J, V_JUMP);
    push(1, ADDI, V_FETCH); push(1, ADDI, V_DECODE); push(1, ADDI, V_ADDIEX); push(1, ADDI, V_ADDIWB);
    push(1, RT, V_FETCH);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL b2b_seq: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    // Bench sits in DECODE of the trailing FETCH above; start a fresh instruction.
    push(1, BAD, V_DECILL); push(1, BAD, V_FETCH); push(1, BAD, V_DECILL); push(1, RT, V_FETCH);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL illegal_op: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout_ok();
    push(1, SW, V_DECODE); push(1, SW, V_MEMADR);
    push(0, SW, V_MEMWR); push(0, SW, V_MEMWR); push(0, SW, V_MEMWR); push(1, SW, V_MEMWR);
    push(1, SW, V_FETCH);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL sw_stall3: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (bus.bus_error !== 1'b0) begin n_err++; $display("FAIL sw_stall3_buserr: got %b need 0", bus.bus_error); end
  endtask

  task automatic test_timeout_fault();
    push(1, SW, V_DECODE); push(1, SW, V_MEMADR);
    push(0, SW, V_MEMWR); push(0, SW, V_MEMWR); push(0, SW, V_MEMWR); push(0, SW, V_MEMWR);
    push(1, SW, V_FAULT); push(1, SW, V_FAULT); push(1, LW, V_FAULT); push(0, LW, V_FAULT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL sw_stall4: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (bus.bus_error !== 1'b1 || bus.state !== 4'd15) begin
      n_err++; $display("FAIL fault_sticky: got err=%b st=%0d need err=1 st=15", bus.bus_error, bus.state);
    end
  endtask

  task automatic test_reset_mid();
    #1 rst = 1'b0; #1;
    n_cmp++;
    if (w_obs !== 21'd0 || bus.bus_error !== 1'b0) begin
      n_err++; $display("FAIL fault_clear: got %h/%b need 000000/0", w_obs, bus.bus_error);
    end
    @(negedge clk);
    rst = 1'b1;
    push(1, SW, V_IDLE); push(1, SW, V_FETCH); push(1, SW, V_DECODE); push(1, SW, V_MEMADR);
    push(0, SW, V_MEMWR); push(0, SW, V_MEMWR);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL pre_abort: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #2 rst = 1'b0; #1;
    n_cmp++;
    if (w_obs !== 21'd0 || bus.bus_error !== 1'b0) begin
      n_err++; $display("FAIL abort_memwr: got %h/%b need 000000/0", w_obs, bus.bus_error);
    end
    @(negedge clk);
    rst = 1'b1;
    push(1, LW, V_IDLE); push(1, LW, V_FETCH); push(1, LW, V_DECODE);
    while (sb.size() > 0) begin
      e = sb.pop_front(); bus.mem_ready = e.rdy; bus.opcode = e.opc; #1;
      n_cmp++;
      if (w_obs !== e.vec) begin n_err++; $display("FAIL post_abort: got %h need %h", w_obs, e.vec); end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_illegal();
    test_timeout_ok();
    test_timeout_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
